mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 13 +
 rtl/mem_arb_id_fifo.sv | 57 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and widths: data width, byte-mask width, and the
// memory request source tag carried through the arbiter's ID FIFO.
package core_pkg;

  localparam int Xlen     = 32;
  localparam int MaskBits = Xlen / 8;

  typedef enum logic {
    SrcFetch,
    SrcData
  } mem_src_e;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Source-ID FIFO for the memory arbiter: remembers which port issued each
// outstanding request so responses can be steered back in order.
module mem_arb_id_fifo
  import core_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  mem_src_e data_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output mem_src_e head_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  mem_src_e    r_mem [Depth];

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) memory arbiter with in-order response steering.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is data-port priority.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int OutstandingDepth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                m0_valid_i,
  output logic                m0_ready_o,
  input  logic [Xlen-1:0]     m0_addr_i,
  input  logic [Xlen-1:0]     m0_wdata_i,
  input  logic [MaskBits-1:0] m0_wmask_i,
  output logic [Xlen-1:0]     m0_rdata_o,
  output logic                m0_rvalid_o,

  input  logic                m1_valid_i,
  output logic                m1_ready_o,
  input  logic [Xlen-1:0]     m1_addr_i,
  input  logic [Xlen-1:0]     m1_wdata_i,
  input  logic [MaskBits-1:0] m1_wmask_i,
  output logic [Xlen-1:0]     m1_rdata_o,
  output logic                m1_rvalid_o,

  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,

  output logic                err_o
);

  typedef enum logic {
    StOpen,
    StLocked
  } arb_state_e;

  arb_state_e r_state;
  mem_src_e   r_lock_src;
  logic       r_err;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  mem_src_e   r_rr_prefer;
`endif

  mem_src_e w_grant;
  mem_src_e w_head;
  logic     w_grant_valid;
  logic     w_issue_ok;
  logic     w_accept;
  logic     w_pop;
  logic     w_full;
  logic     w_empty;

  // A stalled (Locked) request keeps the grant so the downstream sees a stable request.
  always_comb begin
    w_grant = SrcData;
    if (r_state == StLocked) begin
      w_grant = r_lock_src;
    end else if (m0_valid_i && !m1_valid_i) begin
      w_grant = SrcFetch;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    end else if (m0_valid_i && m1_valid_i) begin
      w_grant = r_rr_prefer;
`endif
    end
  end

  assign w_grant_valid = (w_grant == SrcData) ? m1_valid_i : m0_valid_i;
  assign w_issue_ok    = rst_ni && !w_full;
  assign mem_valid_o   = w_issue_ok && w_grant_valid;
  assign w_accept      = mem_valid_o && mem_ready_i;

  assign m0_ready_o = w_issue_ok && (w_grant == SrcFetch) && mem_ready_i;
  assign m1_ready_o = w_issue_ok && (w_grant == SrcData) && mem_ready_i;

  assign mem_addr_o  = (w_grant == SrcData) ? m1_addr_i  : m0_addr_i;
  assign mem_wdata_o = (w_grant == SrcData) ? m1_wdata_i : m0_wdata_i;
  assign mem_wmask_o = (w_grant == SrcData) ? m1_wmask_i : m0_wmask_i;

  // Responses with nothing outstanding are dropped here and flagged via err_o.
  assign w_pop       = mem_rvalid_i && !w_empty;
  assign m0_rvalid_o = rst_ni && w_pop && (w_head == SrcFetch);
  assign m1_rvalid_o = rst_ni && w_pop && (w_head == SrcData);
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign err_o       = r_err;

  mem_arb_id_fifo #(
    .Depth (OutstandingDepth)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_accept),
    .data_i  (w_grant),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= StOpen;
      r_lock_src <= SrcData;
      r_err      <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      r_rr_prefer <= SrcData;
`endif
    end else begin
      if (mem_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (w_accept) begin
        r_rr_prefer <= (w_grant == SrcData) ? SrcFetch : SrcData;
      end
`endif
      case (r_state)
        StOpen: begin
          if (mem_valid_o && !mem_ready_i) begin
            r_state    <= StLocked;
            r_lock_src <= w_grant;
          end
        end
        StLocked: begin
          if (w_accept) begin
            r_state <= StOpen;
          end
        end
        default: r_state <= StOpen;
      endcase
    end
  end

endmodule
